// File: rtl/can_pkg.sv
// Shared CAN bit-level constants and the per-tick action encoding
// used by the transmit stuffer.
package can_pkg;

    localparam logic CAN_RECESSIVE = 1'b1;
    localparam logic CAN_DOMINANT  = 1'b0;

    localparam int DEF_DIV_W       = 16;
    localparam int DEF_STUFF_LIMIT = 5;
    localparam int DEF_CNT_W       = 8;

    typedef enum logic [1:0] {
        ACT_IDLE,
        ACT_STUFF,
        ACT_DATA,
        ACT_UNDERRUN
    } tick_action_e;

endpackage

// File: rtl/can_baud_prescaler.sv
// Bit-rate tick generator; the divisor is captured only while idle so a
// running frame keeps a constant bit time.
module can_baud_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [DIV_W-1:0] baud_div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_reg;
    logic [DIV_W-1:0] div_q_reg;

    always_ff @(posedge sys_clk) begin
        if (reset || !enable) begin
            cnt_reg   <= '0;
            div_q_reg <= baud_div;
        end else if (tick) begin
            cnt_reg   <= '0;
        end else begin
            cnt_reg   <= cnt_reg + 1'b1;
        end
    end

    // Gated so that no boundary is reported while held idle or in reset.
    assign tick = enable && !reset && (cnt_reg == div_q_reg);

endmodule

// File: rtl/can_tx_bit_stuffer.sv
// CAN transmit bit stage: pulls one frame bit per bit time from the
// serializer, inserts stuff bits and drives the registered tx line.
module can_tx_bit_stuffer
    import can_pkg::*;
#(
    parameter int DIV_W       = DEF_DIV_W,
    parameter int STUFF_LIMIT = DEF_STUFF_LIMIT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             enable,
    input  logic             bit_in,
    input  logic             stuff_en,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic             tx,
    output logic             bit_tick,
    output logic             stuff_bit,
    output logic             underrun,
    output logic [CNT_W-1:0] stuff_count
);

    localparam int              RUN_W    = $clog2(STUFF_LIMIT + 1);
    localparam logic [RUN_W-1:0] RUN_FULL = RUN_W'(STUFF_LIMIT);
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);

    logic             tick;
    logic             pending;
    tick_action_e     action;

    logic             tx_reg;
    logic             last_bit_reg;
    logic             region_reg;
    logic [RUN_W-1:0] run_len_reg;
    logic [CNT_W-1:0] stuff_count_reg;

    can_baud_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .sys_clk  (sys_clk),
        .reset    (reset),
        .enable   (enable),
        .baud_div (baud_div),
        .tick     (tick)
    );

    // region_reg is the stuff_en of the last consumed bit, so the stuff bit
    // after the final CRC bit is still emitted once stuff_en has dropped.
    assign pending = (run_len_reg == RUN_FULL) && region_reg;

    always_comb begin
        action = ACT_IDLE;
        if (tick) begin
            if (pending)        action = ACT_STUFF;
            else if (bit_valid) action = ACT_DATA;
            else                action = ACT_UNDERRUN;
        end
    end

    assign bit_tick    = tick;
    assign stuff_bit   = (action == ACT_STUFF);
    assign bit_ready   = (action == ACT_DATA);
    assign underrun    = (action == ACT_UNDERRUN);
    assign tx          = tx_reg;
    assign stuff_count = stuff_count_reg;

    always_ff @(posedge sys_clk) begin
        if (reset || !enable) begin
            tx_reg          <= CAN_RECESSIVE;
            last_bit_reg    <= CAN_RECESSIVE;
            region_reg      <= 1'b0;
            run_len_reg     <= '0;
            stuff_count_reg <= '0;
        end else begin
            unique case (action)
                ACT_STUFF: begin
                    // The stuff bit opens a fresh run and may itself be stuffed.
                    tx_reg       <= ~last_bit_reg;
                    last_bit_reg <= ~last_bit_reg;
                    run_len_reg  <= RUN_ONE;
                    if (stuff_count_reg != '1)
                        stuff_count_reg <= stuff_count_reg + 1'b1;
                end
                ACT_DATA: begin
                    tx_reg       <= bit_in;
                    last_bit_reg <= bit_in;
                    region_reg   <= stuff_en;
                    if (!stuff_en)
                        run_len_reg <= '0;
                    else if (bit_in == last_bit_reg && run_len_reg != '0)
                        run_len_reg <= run_len_reg + 1'b1;
                    else
                        run_len_reg <= RUN_ONE;
                end
                ACT_UNDERRUN: begin
                    tx_reg      <= CAN_RECESSIVE;
                    run_len_reg <= '0;
                    region_reg  <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_can_tx_bit_stuffer.sv
// Scoreboard bench: the driver feeds bit slots and a reference model predicts
// every tick; an independent monitor checks ticks, pulses, tx and bit timing.
module tb_can_tx_bit_stuffer;
    import can_pkg::*;

    localparam int DIV_W = 16;
    localparam int CNT_W = 8;
    localparam int LIMIT = 5;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             sys_clk   = 1'b0;
    logic             reset     = 1'b1;
    logic [DIV_W-1:0] baud_div  = '0;
    logic             enable    = 1'b0;
    logic             bit_in    = 1'b1;
    logic             stuff_en  = 1'b0;
    logic             bit_valid = 1'b0;
    logic             bit_ready;
    logic             tx;
    logic             bit_tick;
    logic             stuff_bit;
    logic             underrun;
    logic [CNT_W-1:0] stuff_count;

    can_tx_bit_stuffer #(
        .DIV_W       (DIV_W),
        .STUFF_LIMIT (LIMIT),
        .CNT_W       (CNT_W)
    ) dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .baud_div    (baud_div),
        .enable      (enable),
        .bit_in      (bit_in),
        .stuff_en    (stuff_en),
        .bit_valid   (bit_valid),
        .bit_ready   (bit_ready),
        .tx          (tx),
        .bit_tick    (bit_tick),
        .stuff_bit   (stuff_bit),
        .underrun    (underrun),
        .stuff_count (stuff_count)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic tx;
        logic stf;
        logic rdy;
        logic und;
    } exp_t;

    typedef struct {
        bit gap;
        bit b;
        bit se;
    } slot_t;

    exp_t  sbq[$];
    slot_t plan[$];
    bit    hist[$];
    bit    region;
    int    model_stuffs;

    int   checks   = 0;
    int   failures = 0;
    bit   mon_on   = 1'b0;
    logic exp_tx   = CAN_RECESSIVE;
    int   cur_div  = 0;
    int   gap_cnt  = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
        end
    endfunction

    // Reference: a stuff bit is due when the last five transmitted bits of the
    // current stuffed region (stuff bits included) are all the same.
    function automatic bit stuff_due();
        if (!region || hist.size() < LIMIT) return 1'b0;
        for (int i = hist.size() - LIMIT; i < hist.size(); i++)
            if (hist[i] != hist[hist.size()-1]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_slot(input slot_t s);
        if (stuff_due()) begin
            bit nb;
            nb = ~hist[hist.size()-1];
            sbq.push_back('{nb, 1'b1, 1'b0, 1'b0});
            hist.push_back(nb);
            if (model_stuffs < CNT_MAX) model_stuffs++;
        end
        if (s.gap) begin
            sbq.push_back('{CAN_RECESSIVE, 1'b0, 1'b0, 1'b1});
            hist.delete();
            region = 1'b0;
        end else begin
            sbq.push_back('{s.b, 1'b0, 1'b1, 1'b0});
            region = s.se;
            if (s.se) hist.push_back(s.b);
            else      hist.delete();
        end
        while (hist.size() > LIMIT) void'(hist.pop_front());
    endtask

    // Monitor: every tick must match the next predicted entry; tx must follow one cycle later.
    always @(negedge sys_clk) begin
        if (mon_on) begin
            exp_t e;
            chk("tx_line", tx, exp_tx);
            if (reset || !enable) gap_cnt = 0;
            else                  gap_cnt++;
            if (bit_tick) begin
                chk("tick_interval", gap_cnt, cur_div + 1);
                gap_cnt = 0;
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_tick t=%0t got=tick expected=none", $time);
                end else begin
                    e = sbq.pop_front();
                    chk("stuff_bit", stuff_bit, e.stf);
                    chk("bit_ready", bit_ready, e.rdy);
                    chk("underrun", underrun, e.und);
                    exp_tx = e.tx;
                end
            end else begin
                chk("idle_pulses", {stuff_bit, bit_ready, underrun}, 3'b000);
            end
        end
    end

    task automatic drive_slot(input slot_t s, output bit ok);
        int n;
        ok = 1'b1;
        n  = 0;
        model_slot(s);
        bit_valid = !s.gap;
        bit_in    = s.gap ? 1'($urandom_range(0, 1)) : s.b;
        stuff_en  = s.se;
        forever begin
            @(negedge sys_clk);
            if (s.gap ? (bit_tick && !stuff_bit) : bit_ready) break;
            n++;
            if (n > 300) begin
                checks++;
                failures++;
                $display("FAIL slot_timeout t=%0t got=no_handshake expected=handshake", $time);
                ok = 1'b0;
                break;
            end
        end
        @(posedge sys_clk);
        #1;
        bit_valid = 1'b0;
    endtask

    task automatic add_bits(input bit b, input bit se, input int count);
        for (int i = 0; i < count; i++) plan.push_back('{1'b0, b, se});
    endtask

    task automatic add_gap();
        plan.push_back('{1'b1, 1'b0, 1'b0});
    endtask

    task automatic run_plan(input int div, input int abort_at, input bit change_div);
        bit ok;
        baud_div = div[DIV_W-1:0];
        cur_div  = div;
        enable   = 1'b0;
        @(posedge sys_clk);
        #1;
        region = 1'b0;
        hist.delete();
        sbq.delete();
        model_stuffs = 0;
        enable = 1'b1;
        for (int i = 0; i < plan.size(); i++) begin
            if (change_div && i == 3) baud_div = baud_div + 16'd7;
            if (i == abort_at) begin
                chk("count_before_abort", stuff_count, model_stuffs);
                reset = 1'b1;
                @(posedge sys_clk);
                #1;
                sbq.delete();
                exp_tx = CAN_RECESSIVE;
                chk("abort_tx", tx, CAN_RECESSIVE);
                chk("abort_count", stuff_count, 0);
                reset  = 1'b0;
                enable = 1'b0;
                return;
            end
            drive_slot(plan[i], ok);
            if (!ok) begin
                enable = 1'b0;
                @(posedge sys_clk);
                #1;
                sbq.delete();
                exp_tx = tx;
                return;
            end
        end
        chk("queue_drained", sbq.size(), 0);
        chk("stuff_count", stuff_count, model_stuffs);
        enable = 1'b0;
        @(posedge sys_clk);
        #1;
        chk("idle_tx", tx, CAN_RECESSIVE);
        chk("idle_count", stuff_count, 0);
    endtask

    task automatic gen_random(input int n);
        bit b;
        bit se;
        b  = 1'($urandom_range(0, 1));
        se = 1'b1;
        plan.delete();
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 99) < 8) begin
                add_gap();
            end else begin
                if ($urandom_range(0, 99) < 25) b = ~b;
                if ($urandom_range(0, 99) < 8)  se = ~se;
                plan.push_back('{1'b0, b, se});
            end
        end
        add_gap();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t got=running expected=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with enable high and a valid bit offered: line must stay idle.
        enable    = 1'b1;
        bit_valid = 1'b1;
        bit_in    = CAN_DOMINANT;
        stuff_en  = 1'b1;
        repeat (3) begin
            @(negedge sys_clk);
            chk("reset_tx", tx, CAN_RECESSIVE);
            chk("reset_count", stuff_count, 0);
            chk("reset_pulses", {bit_tick, bit_ready, stuff_bit, underrun}, 4'b0000);
        end
        @(posedge sys_clk);
        #1;
        reset     = 1'b0;
        enable    = 1'b0;
        bit_valid = 1'b0;
        exp_tx    = CAN_RECESSIVE;
        mon_on    = 1'b1;

        plan.delete(); add_bits(0, 1, 5); add_bits(1, 1, 1); add_gap();
        run_plan(3, -1, 1'b0);

        plan.delete(); add_bits(1, 1, 5); add_bits(0, 1, 4); add_gap();
        run_plan(0, -1, 1'b0);

        plan.delete(); add_bits(1, 1, 5); add_bits(1, 0, 1); add_gap();
        run_plan(1, -1, 1'b0);

        plan.delete(); add_bits(1, 0, 6); add_gap();
        run_plan(2, -1, 1'b0);

        plan.delete(); add_bits(0, 1, 3); add_gap(); add_bits(0, 1, 5); add_bits(1, 1, 1); add_gap();
        run_plan(0, -1, 1'b0);

        plan.delete(); add_bits(0, 1, 5); add_bits(1, 1, 2); add_bits(0, 1, 3);
        run_plan(2, 8, 1'b0);

        for (int r = 0; r < 8; r++) begin
            gen_random(int'($urandom_range(20, 60)));
            run_plan(int'($urandom_range(0, 4)), -1, (r == 2));
        end

        repeat (3) @(posedge sys_clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
